// File: rtl/pulse_train_generator.sv
// Pulse train generator: N pulses of H high cycles separated by L low cycles,
// with a start/busy/done handshake. Define PULSE_TRAIN_ABORT_EN to add an abort input.
module pulse_train_generator #(
  parameter int unsigned HW = 4,
  parameter int unsigned LW = 4,
  parameter int unsigned NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [HW-1:0] high_len,
  input  logic [LW-1:0] low_len,
  input  logic [NW-1:0] num_pulses,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic          abort,
`endif
  output logic          a,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pulse_idx
);

  localparam int unsigned PW = (HW > LW) ? HW : LW;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_cnt, w_cnt;
  logic [HW-1:0] r_high, w_high;
  logic [LW-1:0] r_low, w_low;
  logic [NW-1:0] r_num, w_num;
  logic [NW-1:0] r_idx, w_idx;
  logic          r_a, w_a;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          w_abort;
  logic [HW-1:0] w_h_in;
  logic [LW-1:0] w_l_in;

`ifdef PULSE_TRAIN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Zero lengths behave as one cycle; stored lengths are therefore always >= 1.
  assign w_h_in = (high_len == '0) ? HW'(1) : high_len;
  assign w_l_in = (low_len == '0) ? LW'(1) : low_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_high  <= '0;
      r_low   <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_a     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_high  <= w_high;
      r_low   <= w_low;
      r_num   <= w_num;
      r_idx   <= w_idx;
      r_a     <= w_a;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_high  = r_high;
    w_low   = r_low;
    w_num   = r_num;
    w_idx   = r_idx;
    w_a     = r_a;
    w_busy  = r_busy;
    w_done  = 1'b0;

    case (r_state)
      // DONE accepts a new start exactly like IDLE, allowing back-to-back trains.
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        w_a     = 1'b0;
        w_busy  = 1'b0;
        w_idx   = '0;
        if (start) begin
          w_high = w_h_in;
          w_low  = w_l_in;
          w_num  = num_pulses;
          if (num_pulses != '0) begin
            w_state = S_HIGH;
            w_a     = 1'b1;
            w_busy  = 1'b1;
            w_cnt   = PW'(w_h_in - HW'(1));
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_a = 1'b0;
          if (r_idx == NW'(r_num - NW'(1))) begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_idx   = '0;
          end else begin
            w_state = S_LOW;
            w_cnt   = PW'(r_low - LW'(1));
          end
        end else begin
          w_cnt = r_cnt - PW'(1);
        end
      end
      S_LOW: begin
        if (r_cnt == '0) begin
          w_state = S_HIGH;
          w_a     = 1'b1;
          w_idx   = r_idx + NW'(1);
          w_cnt   = PW'(r_high - HW'(1));
        end else begin
          w_cnt = r_cnt - PW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_a     = 1'b0;
        w_busy  = 1'b0;
        w_idx   = '0;
      end
    endcase

    // Abort drops the train silently: no done strobe.
    if (w_abort && r_busy) begin
      w_state = S_IDLE;
      w_a     = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_idx   = '0;
    end
  end

  assign a         = r_a;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_idx = r_idx;

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Transmit-side counterpart to the team's edge and one-cycle-pulse detectors. On a start request it drives a single-bit line `a` with a programmable train of pulses: N pulses, each H cycles high, separated by L-cycle low gaps. It is used as a stimulus source and as a strobe generator feeding the detector blocks, with a start/busy/done handshake toward the controlling logic.

Parameters:
HW, 4, width of high_len field (pulse high time, cycles)
LW, 4, width of low_len field (gap low time, cycles)
NW, 4, width of num_pulses field and pulse_idx

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only when the block is not busy
high_len  in  HW  pulse high time; 0 treated as 1
low_len  in  LW  gap low time between pulses; 0 treated as 1
num_pulses  in  NW  number of pulses; 0 means no pulses
a  out  1  generated pulse line, registered
busy  out  1  train in progress
done  out  1  one-cycle completion strobe
pulse_idx  out  NW  0-based index of the pulse currently being driven; 0 when idle

Behaviour:
- Reset (rst=0, async): state=IDLE; a=0, busy=0, done=0, pulse_idx=0, all counters cleared. Applies immediately, including mid-train. Train resumes only on a new start after rst=1.
- States: IDLE, HIGH, LOW, DONE. All outputs are registered (driven from flops, not decoded combinationally from inputs).
- IDLE: on start=1, latch high_len, low_len, num_pulses (later input changes are ignored until the next start).
  - num_pulses!=0: go to HIGH, busy=1, a=1 from the next cycle (latency 1).
  - num_pulses==0: go to DONE; a and busy stay 0.
- HIGH: a=1 for exactly max(high_len,1) cycles.
  - At the end: if pulse_idx == num_pulses-1, go to DONE; else go to LOW.
- LOW: a=0 for exactly max(low_len,1) cycles, then go to HIGH and increment pulse_idx.
- DONE: lasts one cycle.
  - done=1, busy=0, a=0, pulse_idx=0.
  - Next state is IDLE.
  - start is accepted in the DONE cycle (behaves as IDLE), so trains can run back-to-back with at least 1 low cycle between them.
- start while busy=1 is ignored; no queuing.
- No trailing gap after the last pulse: done occurs in the first low cycle after the final high phase.
- Total train length from the first a=1 to the done cycle inclusive: N*H + (N-1)*L + 1 cycles.
- Counters:
  - Phase counter sized max(HW,LW) bits, counts down, reloads on each phase entry.
  - Pulse counter NW bits. Maximum values (all ones) must work without wrap errors.
- busy and a are never X after reset. done is never high together with busy.

Optional Feature:
Macro PULSE_TRAIN_ABORT_EN.
- Defined: adds input port `abort` (1 bit). When busy=1 and abort=1 on a rising edge, the next cycle has a=0, busy=0, pulse_idx=0, state IDLE, and no done pulse. abort while idle has no effect. If abort and start arrive in the same idle cycle, start wins.
- Not defined: no abort port; a train always runs to completion or until reset.

Test Plan:
1. Basic train: H=1, L=1, N=3, start at cycle 0 -> a=1,0,1,0,1 on cycles 1-5; done=1 and a=0 on cycle 6; busy=1 on cycles 1-5 only; pulse_idx=0,0,1,1,2.
2. Widths and zero handling: H=3, L=0, N=2 -> a=1,1,1,0,1,1,1 on cycles 1-7, done on cycle 8. N=0 -> done on cycle 1, a and busy stay 0.
3. Detector interop: feed `a` into the existing posedge detector and one-cycle-pulse detector. With H=1, L=2, N=2 the one-cycle-pulse detector fires twice. With H=2 it never fires, while the posedge detector fires once per pulse in both cases.
4. Handshake:
   - start held high through a whole train (H=2, L=1, N=2) -> second train begins the cycle after done, with exactly 1 low cycle between trains.
   - start pulses while busy are ignored.
   - Input changes mid-train do not alter the latched values.
5. Reset mid-train: drop rst at a negedge of clk during HIGH of pulse 1 (N=4) -> a, busy, done and pulse_idx go to 0 immediately, without waiting for a clock edge. After release, no activity until a new start.
6. With PULSE_TRAIN_ABORT_EN: abort during LOW of pulse 0 (H=2, L=3, N=3) -> a stays 0, busy=0 next cycle, done never asserts. A later start runs a full train.
